// File: rtl/fns_serial_dec.sv
// ---------------------------------------------------------------------------
// fns_serial_dec
//
// Serial decoder for 8-bit Fibonacci-number-system (Zeckendorf) codewords.
// Bit k of the codeword carries weight W[k] = 1,2,3,5,8,13,21,34, so the
// largest decodable sum is 87 and the result fits in 7 bits. The block
// accepts one codeword in IDLE and walks it from bit 7 down to bit 0, one
// bit per clock. A codeword that has two adjacent 1 bits is not a canonical
// Zeckendorf form. It still decodes to its weighted sum, and err is raised.
//
// Ports
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  codein holds a codeword to decode
//   in_ready   out  1  block is idle and will take a codeword
//   codein     in   8  FNS codeword
//   out_valid  out  1  dataout/err hold a decoded result
//   out_ready  in   1  downstream takes the result
//   dataout    out  7  decoded binary value (0 while out_valid=0)
//   err        out  1  adjacent-ones flag    (0 while out_valid=0)
//
// Timing: accept edge -> 8 RUN edges -> DONE (out_valid=1) -> release edge
// -> IDLE. At least 10 edges separate two accepts.
// ---------------------------------------------------------------------------
module fns_serial_dec (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] codein,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] dataout,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Fibonacci weight of codeword bit idx.
    function automatic logic [6:0] fib_weight(input logic [2:0] idx);
        logic [6:0] w;
        case (idx)
            3'd0:    w = 7'd1;
            3'd1:    w = 7'd2;
            3'd2:    w = 7'd3;
            3'd3:    w = 7'd5;
            3'd4:    w = 7'd8;
            3'd5:    w = 7'd13;
            3'd6:    w = 7'd21;
            3'd7:    w = 7'd34;
            default: w = 7'd0;
        endcase
        return w;
    endfunction

    state_e     state_q;
    logic [7:0] code_q;      // codeword captured on the accept edge
    logic [2:0] cnt_q;       // bit index processed on the next RUN edge
    logic [6:0] acc_q;       // running weighted sum
    logic       flag_q;      // sticky adjacent-ones flag for this codeword
    logic       in_ready_q;
    logic       out_valid_q;
    logic [6:0] dataout_q;
    logic       err_q;

    logic [2:0] upper_idx_s;
    logic [6:0] term_s;
    logic       adj_s;
    logic [6:0] acc_d;
    logic       flag_d;

    // Per-bit datapath: weight contribution and adjacency check of the current bit.
    always_comb begin
        upper_idx_s = cnt_q + 3'd1;
        if (code_q[cnt_q]) begin
            term_s = fib_weight(cnt_q);
        end else begin
            term_s = 7'd0;
        end
        // Bit 7 has no upper neighbour, and upper_idx_s wraps to 0 there.
        if (cnt_q != 3'd7) begin
            adj_s = code_q[cnt_q] & code_q[upper_idx_s];
        end else begin
            adj_s = 1'b0;
        end
        // The sum cannot exceed 87, so a 7-bit add never overflows.
        acc_d  = acc_q + term_s;
        flag_d = flag_q | adj_s;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= 8'd0;
            cnt_q       <= 3'd0;
            acc_q       <= 7'd0;
            flag_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dataout_q   <= 7'd0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        code_q     <= codein;
                        acc_q      <= 7'd0;
                        flag_q     <= 1'b0;
                        cnt_q      <= 3'd7;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_q  <= acc_d;
                    flag_q <= flag_d;
                    if (cnt_q == 3'd0) begin
                        // The last bit goes straight to the output registers,
                        // so out_valid rises on the 8th edge after the accept.
                        out_valid_q <= 1'b1;
                        dataout_q   <= acc_d;
                        err_q       <= flag_d;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        dataout_q   <= 7'd0;
                        err_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: drop to a clean idle.
                    state_q     <= ST_IDLE;
                    cnt_q       <= 3'd0;
                    acc_q       <= 7'd0;
                    flag_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    dataout_q   <= 7'd0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fns_serial_dec.sv
// ---------------------------------------------------------------------------
// tb_fns_serial_dec
//
// Scoreboard bench for fns_serial_dec. On every accept, the value predicted
// by a Zeckendorf reference model is queued. A negedge monitor pops and
// checks each result that the decoder presents. It also checks the latency,
// the hold under backpressure, the zero outputs while out_valid is low, the
// return to idle, and the spacing of back-to-back accepts.
// ---------------------------------------------------------------------------
module tb_fns_serial_dec;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] codein;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] dataout;
    logic       err;

    fns_serial_dec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .codein    (codein),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .err       (err)
    );

    typedef struct {
        int   value;
        logic flag;
        int   acc_cycle;
    } exp_t;

    exp_t sb[$];
    int   nchecks = 0;
    int   nfail   = 0;
    int   cycle_cnt = 0;
    int   acc_cnt = 0;
    int   res_cnt = 0;
    int   last_acc = 0;
    bit   last_acc_ok = 0;
    bit   b2b_mode = 0;
    bit   rand_ready = 0;
    logic ready_force = 1'b1;
    logic prev_valid = 1'b0;
    logic expect_idle = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference model: the Zeckendorf sum of the set bits.
    function automatic int ref_value(input logic [7:0] c);
        int w[8];
        int s;
        w[0] = 1;
        w[1] = 2;
        for (int k = 2; k < 8; k++) w[k] = w[k-1] + w[k-2];
        s = 0;
        for (int k = 0; k < 8; k++) if (c[k]) s += w[k];
        return s;
    endfunction

    function automatic logic ref_err(input logic [7:0] c);
        logic [7:0] sh;
        sh = c >> 1;
        return |(c & sh);
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int req);
        nchecks++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle_cnt);
        end
    endtask

    // The out_ready driver runs 2 time units after each edge so that it can pick up ready_force.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Negedge monitor: logs accepts and checks every output cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk(in_ready == 1'b1 && out_valid == 1'b0 && dataout == 7'd0 && err == 1'b0,
                "reset_outputs", {in_ready, out_valid, err, 7'(dataout)}, 512);
            prev_valid  <= 1'b0;
            expect_idle <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back('{ref_value(codein), ref_err(codein), cycle_cnt + 1});
                if (b2b_mode && last_acc_ok)
                    chk((cycle_cnt + 1 - last_acc) == 10, "b2b_spacing", cycle_cnt + 1 - last_acc, 10);
                last_acc    <= cycle_cnt + 1;
                last_acc_ok <= 1'b1;
                acc_cnt     <= acc_cnt + 1;
            end
            if (expect_idle)
                chk(out_valid == 1'b0 && in_ready == 1'b1, "release_to_idle",
                    {out_valid, in_ready}, 1);
            if (!out_valid) begin
                chk(dataout == 7'd0 && err == 1'b0, "zero_when_invalid", {err, dataout}, 0);
            end else if (sb.size() == 0) begin
                chk(1'b0, "unexpected_out_valid", 1, 0);
            end else begin
                if (!prev_valid)
                    chk((cycle_cnt - sb[0].acc_cycle) == 8, "latency",
                        cycle_cnt - sb[0].acc_cycle, 8);
                chk(int'(dataout) == sb[0].value, "dataout", dataout, sb[0].value);
                chk(err == sb[0].flag, "err", err, sb[0].flag);
                chk(in_ready == 1'b0, "in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    res_cnt <= res_cnt + 1;
                end
            end
            prev_valid  <= out_valid;
            expect_idle <= out_valid && out_ready;
        end
    end

    // Offer one codeword and wait for it to be accepted. With hold=1, in_valid stays high.
    task automatic send(input logic [7:0] c, input bit hold);
        int n0;
        bit got;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        codein   = c;
        n0  = acc_cnt;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != n0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk(1'b0, "accept_timeout", 0, 1);
        if (!hold) begin
            in_valid = 1'b0;
            codein   = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk(1'b0, "drain_timeout", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] directed [5];
        bit ok;
        directed[0] = 8'b1010_1010;
        directed[1] = 8'b0000_0001;
        directed[2] = 8'b0000_0000;
        directed[3] = 8'b1111_1111;
        directed[4] = 8'b0100_1100;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        codein   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed codewords, with the result taken immediately.
        ready_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(directed[i], 1'b0);
            wait_idle();
        end

        // Backpressure: hold DONE for 5 cycles and offer a decoy codeword there.
        ready_force = 1'b0;
        send(8'b0010_0101, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "bp_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            codein   = 8'($urandom);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        ready_force = 1'b1;
        wait_idle();

        // Reset during the 4th RUN cycle aborts the codeword.
        send(8'b1001_0010, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(in_ready == 1'b1 && out_valid == 1'b0 && dataout == 7'd0 && err == 1'b0,
            "async_reset", {in_ready, out_valid, err, 7'(dataout)}, 512);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'b1000_0000, 1'b0);
        wait_idle();

        // Back-to-back: in_valid held high and out_ready=1.
        b2b_mode    = 1'b1;
        last_acc_ok = 1'b0;
        for (int i = 0; i < 6; i++) send(8'($urandom), (i != 5));
        wait_idle();
        b2b_mode = 1'b0;

        // Random codewords, random gaps, random out_ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle();
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        repeat (3) @(posedge clk);

        chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        chk(res_cnt == acc_cnt - 1, "result_count", res_cnt, acc_cnt - 1);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/fns_serial_dec.md
FNS_SERIAL_DEC -- requirements
Module: fns_serial_dec

Interface
REQ-001 Parameters: none; codeword width 8 and data width 7 are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  codeword on codein is valid.
REQ-005 in_ready  output  1  block can accept a codeword.
REQ-006 codein  input  8  FNS codeword; bit k carries weight W[k].
REQ-007 out_valid  output  1  dataout/err hold a decoded result.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 dataout  output  7  decoded binary value.
REQ-010 err  output  1  codeword contained two adjacent 1 bits.

Function
REQ-011 Weights SHALL be the Fibonacci set W[0..7] = 1, 2, 3, 5, 8, 13, 21, 34; max sum 87, so dataout SHALL be 7 bits with no truncation.
REQ-012 FSM states SHALL be IDLE, RUN and DONE only; an unreachable encoding SHALL return to IDLE on the next edge.
REQ-013 in_ready SHALL be 1 only in IDLE, as a registered state decode with no combinational path from in_valid.
REQ-014 Accept: on an edge where state is IDLE and in_valid=1, the block SHALL latch codein, clear the accumulator and error flag, load bit counter to 7, and enter RUN.
REQ-015 RUN: each edge SHALL add codein_latched[cnt]*W[cnt] to the accumulator, from MSB (bit 7) down to bit 0, one bit per cycle.
REQ-016 RUN: when codein_latched[cnt] and codein_latched[cnt+1] are both 1 (cnt<=6), the error flag SHALL set sticky for this codeword.
REQ-017 RUN: on the edge processing cnt=0, the block SHALL enter DONE; otherwise cnt SHALL decrement.
REQ-018 Latency: out_valid SHALL rise exactly 8 clock edges after the accepting edge, i.e., 8 RUN cycles.
REQ-019 DONE: out_valid=1, and dataout/err SHALL be held stable until the edge where out_ready=1.
REQ-020 On an edge in DONE with out_ready=1, the block SHALL enter IDLE; the next codeword SHALL be accepted no earlier than the following edge, giving a throughput of one codeword per 10 cycles minimum.
REQ-021 in_valid and codein SHALL be ignored in RUN and DONE; changes to codein after acceptance SHALL NOT affect the result.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 dataout and err SHALL read 0 whenever out_valid=0.
REQ-024 Arithmetic SHALL be unsigned; the accumulator SHALL be 7 bits and SHALL never overflow given REQ-011.

Reset
REQ-025 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, dataout=0, err=0, counter=0, accumulator=0 and latched codeword=0, all asynchronously.
REQ-026 Reset asserted in RUN or DONE SHALL abort the codeword with no output produced; after release the block SHALL be in IDLE ready to accept.
REQ-027 Reset release SHALL be synchronous to clk; the first accept can occur on the first edge with rst_n=1.

Verification
REQ-028 codein=8'b1010_1010, in_valid pulse, out_ready=1 -> out_valid high 8 edges after accept; dataout=54, err=0.
REQ-029 codein=8'b0000_0001 -> dataout=1, err=0; codein=8'b0000_0000 -> dataout=0, err=0.
REQ-030 codein=8'b1111_1111 -> dataout=87, err=1; codein=8'b0100_1100 -> dataout=29, err=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, dataout and err stable all 5 cycles; in_ready=0; a codein change with in_valid=1 is ignored; release out_ready -> IDLE next edge.
REQ-032 rst_n pulsed low at RUN cycle 4 -> outputs go to reset values immediately, no out_valid; next codeword 8'b1000_0000 -> dataout=34, err=0.
REQ-033 Back-to-back: in_valid held high with out_ready=1 -> accepts occur exactly 10 edges apart, each result correct.
